// File: rtl/intpulse_gen_if.sv
// Data-bus tap between the MIPS core store path and the interrupt pulse
// generator.
//   memwrite  : store strobe from the core
//   dataadr   : byte address of the store or read (bits [1:0] ignored)
//   writedata : store data
//   readdata  : combinational read-back of the addressed register
// The core side uses the master modport; the peripheral uses slave.
interface intpulse_gen_if;
  logic        memwrite;
  logic [31:0] dataadr;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output memwrite,
    output dataadr,
    output writedata,
    input  readdata
  );

  modport slave (
    input  memwrite,
    input  dataadr,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/intpulse_gen.sv
// Memory-mapped interrupt pulse generator. Software arms per-channel
// countdowns (optionally repeating) or fires channels directly, and the block
// drives registered pulses of PULSE_WIDTH cycles onto the core's 8-bit
// interrupt input. A 16-bit COUNT register tallies every pulse started.
//
// Ports:
//   ph1        : clock, all state changes on its rising edge
//   reset_b    : asynchronous active-low reset, clears all state
//   bus        : store/read tap (memwrite, dataadr, writedata, readdata)
//   interrupts : one registered pulse output per channel
//
// Register window at BASE_ADDR (0x30 bytes):
//   0x00 CTRL   R/W   [7:0] channel enables
//   0x04 STATUS R/W1C [7:0] armed flags
//   0x08 FIRE   W     [7:0] immediate pulse request (reads 0)
//   0x0C COUNT  R/W   [15:0] pulses started, any write clears
//   0x10+4n DELAY[n]  {REPEAT, 7'b0, D[23:0]}
module intpulse_gen #(
  parameter logic [31:0] BASE_ADDR   = 32'hFFFF_0000,
  parameter int          PULSE_WIDTH = 1
) (
  input  logic                 ph1,
  input  logic                 reset_b,
  intpulse_gen_if.slave        bus,
  output logic [7:0]           interrupts
);

  localparam logic [3:0] PW = 4'(PULSE_WIDTH);

  logic [7:0]  ctrl;
  logic [7:0]  armed;
  logic [7:0]  rpt;
  logic [7:0]  fire_pend;
  logic [7:0]  irq;
  logic [15:0] pulse_count;
  logic [23:0] dly  [8];
  logic [23:0] cnt  [8];
  logic [3:0]  wcnt [8];

  logic [31:0] offset;
  logic        in_window;
  logic [3:0]  reg_idx;
  logic [2:0]  dly_sel;
  logic        wr;
  logic        wr_ctrl;
  logic        wr_status;
  logic        wr_fire;
  logic        wr_count;
  logic [7:0]  wr_delay;
  logic [7:0]  expire;
  logic [7:0]  start;
  logic [3:0]  num_starts;
  logic        unused_bits;

  // Word-aligned offset into the window; addresses below the base wrap to a
  // large value and so fall outside the window as well.
  assign offset    = {bus.dataadr[31:2], 2'b00} - BASE_ADDR;
  assign in_window = (offset < 32'h30);
  assign reg_idx   = offset[5:2];
  assign dly_sel   = reg_idx[2:0] - 3'd4;
  assign unused_bits = ^{bus.dataadr[1:0], bus.writedata[30:24]};

  assign wr        = bus.memwrite && in_window;
  assign wr_ctrl   = wr && (reg_idx == 4'd0);
  assign wr_status = wr && (reg_idx == 4'd1);
  assign wr_fire   = wr && (reg_idx == 4'd2);
  assign wr_count  = wr && (reg_idx == 4'd3);

  always_comb begin
    wr_delay = '0;
    for (int n = 0; n < 8; n++) begin
      wr_delay[n] = wr && (reg_idx == 4'(n + 4));
    end
  end

  // A channel expires when it is armed, enabled and its countdown is spent.
  // A DELAY write or STATUS clear landing on the same edge overrides the
  // expiry and suppresses its pulse; a pending FIRE always starts one.
  always_comb begin
    expire     = '0;
    start      = '0;
    num_starts = '0;
    for (int n = 0; n < 8; n++) begin
      expire[n] = armed[n] && ctrl[n] && (cnt[n] == 24'd0);
      start[n]  = fire_pend[n] ||
                  (expire[n] && !wr_delay[n] && !(wr_status && bus.writedata[n]));
      num_starts = num_starts + {3'b000, start[n]};
    end
  end

  // Global registers. FIRE is captured on the write edge (gated by the
  // enables at that moment) and launched on the next edge, so that a FIRE
  // and a zero-length DELAY produce identically timed pulses.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      ctrl        <= '0;
      fire_pend   <= '0;
      pulse_count <= '0;
    end else begin
      if (wr_ctrl) begin
        ctrl <= bus.writedata[7:0];
      end
      fire_pend <= wr_fire ? (bus.writedata[7:0] & ctrl) : 8'h00;
      if (wr_count) begin
        pulse_count <= '0;
      end else begin
        pulse_count <= pulse_count + {12'h000, num_starts};
      end
    end
  end

  // Per-channel countdown. Writes take priority over the countdown; a
  // disabled channel simply holds its count and armed flag.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      armed <= '0;
      rpt   <= '0;
      for (int n = 0; n < 8; n++) begin
        dly[n] <= '0;
        cnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (wr_delay[n]) begin
          dly[n]   <= bus.writedata[23:0];
          cnt[n]   <= bus.writedata[23:0];
          rpt[n]   <= bus.writedata[31];
          armed[n] <= 1'b1;
        end else if (wr_status && bus.writedata[n]) begin
          armed[n] <= 1'b0;
        end else if (armed[n] && ctrl[n]) begin
          if (cnt[n] != 24'd0) begin
            cnt[n] <= cnt[n] - 24'd1;
          end else if (rpt[n]) begin
            cnt[n] <= dly[n];
          end else begin
            armed[n] <= 1'b0;
          end
        end
      end
    end
  end

  // Pulse shaping. The output flop tracks the next width count being
  // non-zero, so it rises on the start edge and falls PULSE_WIDTH edges
  // later; a restart during a pulse just reloads the width.
  always_ff @(posedge ph1 or negedge reset_b) begin
    if (!reset_b) begin
      irq <= '0;
      for (int n = 0; n < 8; n++) begin
        wcnt[n] <= '0;
      end
    end else begin
      for (int n = 0; n < 8; n++) begin
        if (start[n]) begin
          wcnt[n] <= PW;
          irq[n]  <= (PW != 4'd0);
        end else if (wcnt[n] != 4'd0) begin
          wcnt[n] <= wcnt[n] - 4'd1;
          irq[n]  <= (wcnt[n] != 4'd1);
        end else begin
          irq[n] <= 1'b0;
        end
      end
    end
  end

  assign interrupts = irq;

  // Register read-back; everything outside the window reads as zero.
  always_comb begin
    bus.readdata = '0;
    if (in_window) begin
      case (reg_idx)
        4'd0:    bus.readdata = {24'h000000, ctrl};
        4'd1:    bus.readdata = {24'h000000, armed};
        4'd2:    bus.readdata = '0;
        4'd3:    bus.readdata = {16'h0000, pulse_count};
        default: bus.readdata = {rpt[dly_sel], 7'h00, dly[dly_sel]};
      endcase
    end
  end

endmodule

// File: tb/tb_intpulse_gen.sv
// Self-checking bench for intpulse_gen. Two instances (PULSE_WIDTH 1 and 4)
// see identical bus traffic; a cycle-stepped reference model built from the
// register-map rules tracks expected read-back and pulse windows (pulses are
// kept as absolute end times rather than width counters).
module tb_intpulse_gen;

  localparam logic [31:0] BASE       = 32'hFFFF_0000;
  localparam logic [31:0] OFF_CTRL   = 32'h00;
  localparam logic [31:0] OFF_STATUS = 32'h04;
  localparam logic [31:0] OFF_FIRE   = 32'h08;
  localparam logic [31:0] OFF_COUNT  = 32'h0C;
  localparam logic [31:0] OFF_DELAY  = 32'h10;

  logic       ph1;
  logic       reset_b;
  logic [7:0] irq1;
  logic [7:0] irq4;
  logic [31:0] cur_adr;

  int vectors;
  int miscompares;

  intpulse_gen_if bus1 ();
  intpulse_gen_if bus4 ();

  intpulse_gen #(.BASE_ADDR(BASE), .PULSE_WIDTH(1)) u_dut1 (
    .ph1(ph1), .reset_b(reset_b), .bus(bus1), .interrupts(irq1)
  );

  intpulse_gen #(.BASE_ADDR(BASE), .PULSE_WIDTH(4)) u_dut4 (
    .ph1(ph1), .reset_b(reset_b), .bus(bus4), .interrupts(irq4)
  );

  initial begin
    ph1 = 1'b0;
    forever #5 ph1 = ~ph1;
  end

  // Reference model state
  int          cyc;
  logic [7:0]  m_ctrl;
  logic [7:0]  m_armed;
  bit          m_rep [8];
  logic [23:0] m_d   [8];
  int          m_cnt [8];
  int          m_count;
  int          fire_at [8];
  int          end1 [8];
  int          end4 [8];

  function automatic void model_reset();
    m_ctrl  = '0;
    m_armed = '0;
    m_count = 0;
    for (int n = 0; n < 8; n++) begin
      m_rep[n]   = 1'b0;
      m_d[n]     = '0;
      m_cnt[n]   = 0;
      fire_at[n] = -1;
      end1[n]    = 0;
      end4[n]    = 0;
    end
  endfunction

  function automatic int decode(input logic [31:0] adr);
    logic [31:0] off;
    off = {adr[31:2], 2'b00} - BASE;
    if (off >= 32'h30) return -1;
    return int'(off >> 2);
  endfunction

  function automatic logic [31:0] model_read(input logic [31:0] adr);
    int idx;
    idx = decode(adr);
    if (idx < 0) return 32'h0;
    case (idx)
      0: return {24'h0, m_ctrl};
      1: return {24'h0, m_armed};
      2: return 32'h0;
      3: return 32'(m_count);
      default: return {m_rep[idx-4], 7'h0, m_d[idx-4]};
    endcase
  endfunction

  // One clock edge of the spec's behaviour. Decisions use pre-edge state;
  // register writes are applied afterwards and take precedence.
  function automatic void model_edge(input logic mw, input logic [31:0] adr,
                                     input logic [31:0] wd);
    int idx;
    int starts;
    bit st;
    idx = mw ? decode(adr) : -1;
    cyc++;
    starts = 0;
    for (int n = 0; n < 8; n++) begin
      st = (fire_at[n] == cyc);
      if (m_armed[n] && m_ctrl[n]) begin
        if (m_cnt[n] > 0) begin
          m_cnt[n]--;
        end else begin
          if (!(idx == 4 + n || (idx == 1 && wd[n]))) st = 1'b1;
          if (m_rep[n]) m_cnt[n] = int'(m_d[n]);
          else          m_armed[n] = 1'b0;
        end
      end
      if (st) begin
        starts++;
        end1[n] = cyc + 1;
        end4[n] = cyc + 4;
      end
      if (idx == 2 && wd[n] && m_ctrl[n]) fire_at[n] = cyc + 1;
    end
    if (idx == 0) m_ctrl = wd[7:0];
    if (idx == 1) m_armed = m_armed & ~wd[7:0];
    if (idx >= 4) begin
      m_d[idx-4]     = wd[23:0];
      m_rep[idx-4]   = wd[31];
      m_cnt[idx-4]   = int'(wd[23:0]);
      m_armed[idx-4] = 1'b1;
    end
    if (idx == 3) m_count = 0;
    else          m_count = (m_count + starts) % 65536;
  endfunction

  function automatic logic [7:0] exp_irq(input int pw);
    logic [7:0] r;
    for (int n = 0; n < 8; n++) begin
      r[n] = (pw == 1) ? (cyc < end1[n]) : (cyc < end4[n]);
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
    cur_adr        = adr;
    bus1.memwrite  = mw;
    bus1.dataadr   = adr;
    bus1.writedata = wd;
    bus4.memwrite  = mw;
    bus4.dataadr   = adr;
    bus4.writedata = wd;
  endtask

  // Apply one bus cycle, advance the model on the same edge, then compare
  // both instances a little after the edge.
  task automatic step(input logic mw, input logic [31:0] adr, input logic [31:0] wd);
    drive(mw, adr, wd);
    @(posedge ph1);
    model_edge(mw, adr, wd);
    #2;
    chk("irq_pw1",  {24'h0, irq1}, {24'h0, exp_irq(1)});
    chk("irq_pw4",  {24'h0, irq4}, {24'h0, exp_irq(4)});
    chk("read_pw1", bus1.readdata, model_read(cur_adr));
    chk("read_pw4", bus4.readdata, model_read(cur_adr));
  endtask

  task automatic wr(input logic [31:0] off, input logic [31:0] wd);
    step(1'b1, BASE + off, wd);
  endtask

  task automatic idle(input logic [31:0] off);
    step(1'b0, BASE + off, 32'h0);
  endtask

  // With reset held, every register and some out-of-window addresses read 0.
  task automatic reset_readback();
    logic [31:0] outside [3];
    outside[0] = BASE + 32'h30;
    outside[1] = BASE - 32'h4;
    outside[2] = 32'h0000_0010;
    for (int i = 0; i < 12; i++) begin
      drive(1'b0, BASE + 32'(4 * i), 32'h0);
      #1;
      chk("reset_read_pw1", bus1.readdata, 32'h0);
      chk("reset_read_pw4", bus4.readdata, 32'h0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, outside[i], 32'h0);
      #1;
      chk("outside_read", bus1.readdata, 32'h0);
    end
  endtask

  int          first_t;
  int          high_cycles;
  int          rises;
  bit          prev;
  int          op;
  int          ch;
  logic [31:0] rnd;
  logic [31:0] radr;

  initial begin
    vectors     = 0;
    miscompares = 0;
    cyc         = 0;
    model_reset();
    reset_b = 1'b0;
    drive(1'b0, 32'h0, 32'h0);
    #1;
    chk("reset_irq_pw1", {24'h0, irq1}, 32'h0);
    chk("reset_irq_pw4", {24'h0, irq4}, 32'h0);
    reset_readback();
    @(negedge ph1);
    reset_b = 1'b1;

    $display("[TB] immediate FIRE");
    wr(OFF_CTRL, 32'h03);
    wr(OFF_FIRE, 32'h01);
    chk("fire_same_edge", {24'h0, irq1}, 32'h0);
    idle(OFF_COUNT);
    chk("fire_pulse", {24'h0, irq1}, 32'h01);
    chk("fire_count", bus1.readdata, 32'd1);
    idle(OFF_COUNT);
    chk("fire_end", {24'h0, irq1}, 32'h0);
    wr(OFF_FIRE, 32'h04);
    idle(OFF_COUNT);
    chk("fire_disabled_irq", {24'h0, irq1}, 32'h0);
    chk("fire_disabled_count", bus1.readdata, 32'd1);

    $display("[TB] one-shot DELAY");
    wr(OFF_CTRL, 32'h02);
    wr(OFF_DELAY + 32'h4, 32'd9);
    first_t = -1;
    high_cycles = 0;
    for (int t = 1; t <= 15; t++) begin
      idle(OFF_STATUS);
      if (irq1[1]) begin
        high_cycles++;
        if (first_t < 0) first_t = t;
      end
    end
    chk("delay9_rise", 32'(first_t), 32'd10);
    chk("delay9_width", 32'(high_cycles), 32'd1);
    chk("delay9_status", bus1.readdata, 32'h0);

    $display("[TB] repeating DELAY");
    wr(OFF_COUNT, 32'h0);
    wr(OFF_CTRL, 32'h01);
    wr(OFF_DELAY, 32'h8000_0004);
    rises = 0;
    first_t = -1;
    prev = 1'b0;
    for (int t = 1; t <= 40; t++) begin
      idle(OFF_COUNT);
      if (irq1[0] && !prev) rises++;
      prev = irq1[0];
      if (rises == 4) begin
        first_t = t;
        break;
      end
    end
    chk("repeat_4th_rise", 32'(first_t), 32'd20);
    wr(OFF_STATUS, 32'h01);
    prev = irq1[0];
    rises = 0;
    for (int t = 0; t < 20; t++) begin
      idle(OFF_COUNT);
      if (irq1[0] && !prev) rises++;
      prev = irq1[0];
    end
    chk("repeat_after_clear", 32'(rises), 32'd0);
    chk("repeat_count", bus1.readdata, 32'd4);

    $display("[TB] paused countdown");
    wr(OFF_COUNT, 32'h0);
    wr(OFF_DELAY, 32'd20);
    first_t = -1;
    for (int t = 1; t <= 40; t++) begin
      if (t == 6)       wr(OFF_CTRL, 32'h00);
      else if (t == 13) wr(OFF_CTRL, 32'h01);
      else              idle(OFF_STATUS);
      if (irq1[0] && first_t < 0) first_t = t;
    end
    chk("pause_rise", 32'(first_t), 32'd28);

    $display("[TB] FIRE coinciding with expiry");
    wr(OFF_COUNT, 32'h0);
    wr(OFF_DELAY, 32'd3);
    high_cycles = 0;
    for (int t = 1; t <= 8; t++) begin
      if (t == 3) wr(OFF_FIRE, 32'h01);
      else        idle(OFF_COUNT);
      if (irq1[0]) high_cycles++;
    end
    chk("coincide_width", 32'(high_cycles), 32'd1);
    chk("coincide_count", bus1.readdata, 32'd1);

    $display("[TB] COUNT wrap");
    wr(OFF_CTRL, 32'h1F);
    for (int n = 0; n < 5; n++) wr(OFF_DELAY + 32'(4 * n), 32'h8000_0000);
    wr(OFF_COUNT, 32'h0);
    repeat (13107) idle(OFF_COUNT);
    chk("count_preset", bus1.readdata, 32'h0000_FFFF);
    wr(OFF_STATUS, 32'h1F);
    wr(OFF_CTRL, 32'hFF);
    wr(OFF_FIRE, 32'hFF);
    idle(OFF_COUNT);
    chk("count_wrap", bus1.readdata, 32'h0000_0007);

    $display("[TB] reset mid-pulse");
    wr(OFF_FIRE, 32'h01);
    idle(OFF_STATUS);
    idle(OFF_STATUS);
    chk("pw4_high", {31'h0, irq4[0]}, 32'h1);
    reset_b = 1'b0;
    #1;
    model_reset();
    chk("reset_drop_pw4", {24'h0, irq4}, 32'h0);
    chk("reset_drop_pw1", {24'h0, irq1}, 32'h0);
    reset_readback();
    @(negedge ph1);
    reset_b = 1'b1;

    $display("[TB] randomized traffic");
    for (int i = 0; i < 1500; i++) begin
      op  = $urandom_range(0, 11);
      rnd = $urandom;
      radr = 32'($urandom_range(0, 3));
      case (op)
        0:       step(1'b1, BASE + OFF_CTRL + radr, rnd);
        1:       step(1'b1, BASE + OFF_STATUS + radr, {24'h0, rnd[7:0] & rnd[15:8]});
        2, 3:    step(1'b1, BASE + OFF_FIRE + radr, rnd);
        4:       step(1'b1, BASE + OFF_COUNT + radr, rnd);
        5, 6: begin
          ch = $urandom_range(0, 7);
          step(1'b1, BASE + OFF_DELAY + 32'(4 * ch) + radr,
               {rnd[31:24], 20'h0, 4'($urandom_range(0, 12))});
        end
        7:       step(1'b1, (rnd[0] ? BASE + 32'h30 : BASE - 32'h4) + radr, 32'hFFFF_FFFF);
        default: step(1'b0, BASE + 32'(4 * $urandom_range(0, 12)) + radr, 32'h0);
      endcase
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/intpulse_gen.md
# intpulse_gen

Memory-mapped interrupt pulse generator on the data bus of the MIPS core. Software stores to its registers to arm per-line countdowns, or to fire lines at once; the block then drives timed pulses onto the core's 8-bit `interrupts` input. Self-checking programs use it to create interrupt sequences in hardware instead of from a bench. It taps the `memwrite`/`dataadr`/`writedata` store path and returns register contents on `readdata`.

## Interface
- `BASE_ADDR`, default 32'hFFFF_0000: word-aligned base of the 0x30-byte register window.
- `PULSE_WIDTH`, default 1: high time of each pulse, in ph1 cycles; legal range 1..15.
- `ph1`  in  1: the single clock; all state updates on its rising edge.
- `reset_b`  in  1: asynchronous, active-low reset; it clears all state immediately.
- `memwrite`  in  1: store strobe from the core.
- `dataadr`  in  32: byte address for stores and reads; bits [1:0] are ignored.
- `writedata`  in  32: store data.
- `readdata`  out  32: combinational read of the register addressed by `dataadr`; 0 when the address is outside the window or unmapped.
- `interrupts`  out  8: pulse outputs, registered, one per channel.

## Operation
Register map (offsets from `BASE_ADDR`):
- 0x00 CTRL, R/W: bits [7:0] are the per-channel enables.
- 0x04 STATUS, R/W1C: bits [7:0] are the armed flags. Writing 1 to a bit disarms that channel without pulsing.
- 0x08 FIRE, W: each bit set triggers an immediate pulse on that channel. Reads return 0.
- 0x0C COUNT, R/W: bits [15:0] hold total pulses started, modulo 2^16. Any write clears it to 0.
- 0x10 + 4n DELAY[n], n = 0..7, R/W:
  - bits [23:0] are the reload value D.
  - bit 31 is REPEAT.
  - A write stores D and REPEAT, loads the counter with D, and sets armed[n]. This applies even if the channel is already armed.
  - A read returns {REPEAT, 7'b0, D}.

Per-channel state: armed flag, 24-bit countdown `cnt`, 4-bit width counter `wcnt`.

Channel n advances only when armed and CTRL[n] = 1:
- cnt ≠ 0: decrement.
- cnt = 0: expire.
  - Start a pulse.
  - If REPEAT = 1, reload cnt with D and stay armed.
  - If REPEAT = 0, clear armed.

When CTRL[n] = 0, cnt and armed hold (the countdown pauses). A FIRE to a disabled channel is ignored.

Pulse start:
- `wcnt` is set to PULSE_WIDTH and `interrupts[n]` is driven high.
- While wcnt ≠ 0 it decrements; `interrupts[n]` = (wcnt ≠ 0) as a registered output.
- A new start during an active pulse reloads wcnt, extending the pulse, and counts as a new pulse.

COUNT:
- Adds the number of channels starting a pulse in that cycle (0..8) and wraps at 16 bits.
- A clear in the same cycle as starts wins; that cycle's starts are not counted.

Simultaneous events on the same channel in one cycle:
- FIRE and expiry together give one pulse, counted once.
- A DELAY write and expiry together: the write wins (reload and arm), and the expiry pulse is dropped.
- A STATUS clear and expiry together: the clear wins, with no pulse.

Reset (`reset_b` low): `interrupts` = 0, `readdata` reflects zeroed registers, and CTRL, armed, D, REPEAT, cnt, wcnt and COUNT all = 0. Reset in the middle of a pulse drops the output low immediately.

## Timing
- A store is captured on the ph1 edge where `memwrite` = 1 and the address matches.
- FIRE written at edge k: `interrupts[n]` is high from edge k+1 through edge k+PULSE_WIDTH, and low after edge k+1+PULSE_WIDTH.
- DELAY = D written at edge k, channel enabled throughout: the pulse rises at edge k+D+1. D = 0 behaves like FIRE.
- With REPEAT set, the pulse period is D+1 cycles. If PULSE_WIDTH ≥ D+1, the output stays high continuously and COUNT still increments every period.
- If the channel is disabled for m cycles while armed, expiry is delayed by exactly m cycles.
- `readdata` is combinational and reflects state after the most recent edge.

## Test plan
- Reset, then CTRL = 0x03 and FIRE = 0x01, PULSE_WIDTH = 1 → `interrupts` = 0x01 for exactly one cycle after the FIRE edge; COUNT reads 1; FIRE = 0x04 (channel 2 disabled) → no pulse, COUNT stays 1.
- CTRL = 0x02 and DELAY[1] = 9 at edge k → `interrupts[1]` rises at edge k+10 and lasts one cycle; STATUS reads 0 afterwards.
- DELAY[0] = 0x8000_0004 with channel 0 enabled → pulses every 5 cycles; after 4 pulses, STATUS write 0x01 → no further pulses and COUNT = 4.
- Armed channel with D = 20, CTRL cleared for 7 cycles mid-count → pulse 7 cycles late; same-cycle FIRE and expiry → a single pulse and COUNT += 1.
- COUNT preset to near wrap (0xFFFF after 65535 FIREs on channel 0, or force) plus FIRE = 0xFF with all channels enabled → COUNT = 0x0007.
- `reset_b` asserted mid-pulse with PULSE_WIDTH = 4 → `interrupts` goes to 0 asynchronously; all registers read 0; reads outside the window return 0.
